// File: rtl/axi_master_arbiter_pkg.sv
// Shared definitions for the two-requester AXI4-lite master arbiter:
// FSM state encodings, requester count, AXI response codes and default widths.
package axi_master_arbiter_pkg;

  localparam int ARB_NREQ     = 2;
  localparam int AXI_ADDR_W   = 32;
  localparam int AXI_DATA_W   = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b10
  } arb_state_t;

endpackage

// File: rtl/axi_master_arbiter_pick.sv
// Combinational winner select for the arbiter.
// Default build: round-robin; on a tie the requester that did not win last time wins.
// With AXI_ARB_FIXED_PRIO_EN defined: r1 (data port) always wins a tie and last_id
// is ignored, so r0 can starve.
module axi_master_arbiter_pick
  import axi_master_arbiter_pkg::*;
(
  input  logic [ARB_NREQ-1:0] req,
  input  logic                last_id,
  output logic                winner
);

`ifdef AXI_ARB_FIXED_PRIO_EN
  // last_id has no meaning under fixed priority
  logic unused_last_id;
  assign unused_last_id = last_id;

  // r1 wins whenever it requests, otherwise r0
  always_comb begin
    winner = req[1];
  end
`else
  // Tie goes to the requester other than the previous winner; a lone requester wins outright
  always_comb begin
    winner = 1'b0;
    if (req[0] && req[1]) begin
      winner = ~last_id;
    end else begin
      winner = req[1];
    end
  end
`endif

endmodule

// File: rtl/axi_master_arbiter.sv
// Two-requester arbiter in front of a single AXI4-lite master.
// Grants one requester, latches its command, strobes M_access for one cycle,
// then waits for the master to complete and routes data/response back to the
// granted requester only. Tie policy lives in axi_master_arbiter_pick and is
// switched to fixed priority by defining AXI_ARB_FIXED_PRIO_EN.
module axi_master_arbiter
  import axi_master_arbiter_pkg::*;
#(
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W,
  parameter int STRB_W = DATA_W / 8
)(
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              r0_req,
  input  logic              r0_rd0_wr1,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [STRB_W-1:0] r0_wstrb,
  output logic              r0_gnt,
  output logic              r0_done,
  output logic [DATA_W-1:0] r0_rdata,
  output logic [1:0]        r0_resp,
  input  logic              r1_req,
  input  logic              r1_rd0_wr1,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [STRB_W-1:0] r1_wstrb,
  output logic              r1_gnt,
  output logic              r1_done,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [1:0]        r1_resp,
  output logic              M_access,
  output logic              M_rd0_wr1,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] M_write_data,
  output logic [STRB_W-1:0] M_write_strobe,
  input  logic              ready_M,
  input  logic [DATA_W-1:0] read_data_M,
  input  logic              read_data_valid_M,
  input  logic [1:0]        resp_M
);

  arb_state_t        state_reg, state_next;
  logic              gnt_id_reg, gnt_id_next;
  logic              last_id_reg, last_id_next;
  logic              m_rd0_wr1_reg, m_rd0_wr1_next;
  logic [ADDR_W-1:0] m_addr_reg, m_addr_next;
  logic [DATA_W-1:0] m_wdata_reg, m_wdata_next;
  logic [STRB_W-1:0] m_wstrb_reg, m_wstrb_next;

  logic [ARB_NREQ-1:0] req_vec;
  logic                winner;

  assign req_vec = {r1_req, r0_req};

  axi_master_arbiter_pick u_pick (
    .req     (req_vec),
    .last_id (last_id_reg),
    .winner  (winner)
  );

  // State, grant bookkeeping and latched command; last_id resets to 1 so r0 wins the first tie
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg     <= ARB_IDLE;
      gnt_id_reg    <= 1'b0;
      last_id_reg   <= 1'b1;
      m_rd0_wr1_reg <= 1'b0;
      m_addr_reg    <= '0;
      m_wdata_reg   <= '0;
      m_wstrb_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_id_reg    <= gnt_id_next;
      last_id_reg   <= last_id_next;
      m_rd0_wr1_reg <= m_rd0_wr1_next;
      m_addr_reg    <= m_addr_next;
      m_wdata_reg   <= m_wdata_next;
      m_wstrb_reg   <= m_wstrb_next;
    end
  end

  // Next state: grant from IDLE when the master is free, one ISSUE cycle, WAIT for completion
  always_comb begin
    state_next     = state_reg;
    gnt_id_next    = gnt_id_reg;
    last_id_next   = last_id_reg;
    m_rd0_wr1_next = m_rd0_wr1_reg;
    m_addr_next    = m_addr_reg;
    m_wdata_next   = m_wdata_reg;
    m_wstrb_next   = m_wstrb_reg;
    case (state_reg)
      ARB_IDLE: begin
        if ((|req_vec) && ready_M) begin
          state_next   = ARB_ISSUE;
          gnt_id_next  = winner;
          last_id_next = winner;
          if (winner) begin
            m_rd0_wr1_next = r1_rd0_wr1;
            m_addr_next    = r1_addr;
            m_wdata_next   = r1_wdata;
            m_wstrb_next   = r1_wstrb;
          end else begin
            m_rd0_wr1_next = r0_rd0_wr1;
            m_addr_next    = r0_addr;
            m_wdata_next   = r0_wdata;
            m_wstrb_next   = r0_wstrb;
          end
        end
      end
      // ready_M is pulled low by M_access here, so it is deliberately ignored
      ARB_ISSUE: state_next = ARB_WAIT;
      ARB_WAIT: begin
        if (ready_M) begin
          state_next = ARB_IDLE;
        end
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  logic              owns;
  logic              complete;
  logic [DATA_W-1:0] rdata_src;

  assign owns      = (state_reg == ARB_ISSUE) || (state_reg == ARB_WAIT);
  assign complete  = (state_reg == ARB_WAIT) && ready_M;
  assign rdata_src = read_data_valid_M ? read_data_M : '0;

  logic [ARB_NREQ-1:0] gnt_vec;
  logic [ARB_NREQ-1:0] done_vec;
  logic [DATA_W-1:0]   rdata_vec [ARB_NREQ];
  logic [1:0]          resp_vec  [ARB_NREQ];

  // Per-requester return path: only the granted requester ever sees done/data/response
  genvar gi;
  generate
    for (gi = 0; gi < ARB_NREQ; gi++) begin : g_req
      localparam logic REQ_ID = 1'(gi);
      assign gnt_vec[gi]   = owns && (gnt_id_reg == REQ_ID);
      assign done_vec[gi]  = complete && (gnt_id_reg == REQ_ID);
      assign rdata_vec[gi] = done_vec[gi] ? rdata_src : '0;
      assign resp_vec[gi]  = done_vec[gi] ? resp_M : AXI_RESP_OKAY;
    end
  endgenerate

  assign r0_gnt   = gnt_vec[0];
  assign r1_gnt   = gnt_vec[1];
  assign r0_done  = done_vec[0];
  assign r1_done  = done_vec[1];
  assign r0_rdata = rdata_vec[0];
  assign r1_rdata = rdata_vec[1];
  assign r0_resp  = resp_vec[0];
  assign r1_resp  = resp_vec[1];

  assign M_access       = (state_reg == ARB_ISSUE);
  assign M_rd0_wr1      = m_rd0_wr1_reg;
  assign M_addr         = m_addr_reg;
  assign M_write_data   = m_wdata_reg;
  assign M_write_strobe = m_wstrb_reg;

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Self-checking bench for axi_master_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of the grant policy.
// Honors AXI_ARB_FIXED_PRIO_EN to select the expected tie policy.
module tb_axi_master_arbiter;

`ifdef AXI_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b1;
  logic        req   [2];
  logic        rw    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        gnt   [2];
  logic        done  [2];
  logic [31:0] rdata [2];
  logic [1:0]  resp  [2];
  logic        M_access, M_rd0_wr1;
  logic [31:0] M_addr, M_write_data;
  logic [3:0]  M_write_strobe;
  logic        ready_M, read_data_valid_M;
  logic [31:0] read_data_M;
  logic [1:0]  resp_M;

  int n_checks = 0;
  int n_pass = 0;
  int model_last = 1;

  // slave-side model of the AXI master: accepts on M_access, completes after cfg_lat cycles
  int          cfg_lat = 1;
  logic [31:0] cfg_data = 32'h0;
  logic [1:0]  cfg_resp = 2'b00;
  logic        sl_busy;
  int          sl_cnt;
  logic        sl_wr;
  logic [31:0] sl_data;
  logic [1:0]  sl_resp;

  always #5 ACLK = ~ACLK;

  axi_master_arbiter dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .r0_req(req[0]), .r0_rd0_wr1(rw[0]), .r0_addr(addr[0]), .r0_wdata(wdata[0]), .r0_wstrb(wstrb[0]),
    .r0_gnt(gnt[0]), .r0_done(done[0]), .r0_rdata(rdata[0]), .r0_resp(resp[0]),
    .r1_req(req[1]), .r1_rd0_wr1(rw[1]), .r1_addr(addr[1]), .r1_wdata(wdata[1]), .r1_wstrb(wstrb[1]),
    .r1_gnt(gnt[1]), .r1_done(done[1]), .r1_rdata(rdata[1]), .r1_resp(resp[1]),
    .M_access(M_access), .M_rd0_wr1(M_rd0_wr1), .M_addr(M_addr),
    .M_write_data(M_write_data), .M_write_strobe(M_write_strobe),
    .ready_M(ready_M), .read_data_M(read_data_M),
    .read_data_valid_M(read_data_valid_M), .resp_M(resp_M)
  );

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      sl_busy <= 1'b0; sl_cnt <= 0; sl_wr <= 1'b0; sl_data <= 32'h0; sl_resp <= 2'b00;
    end else if (M_access) begin
      sl_busy <= 1'b1; sl_cnt <= cfg_lat; sl_wr <= M_rd0_wr1; sl_data <= cfg_data; sl_resp <= cfg_resp;
    end else if (sl_busy) begin
      if (sl_cnt == 0) sl_busy <= 1'b0;
      else sl_cnt <= sl_cnt - 1;
    end
  end

  assign ready_M           = !M_access && (!sl_busy || sl_cnt == 0);
  assign read_data_valid_M = sl_busy && (sl_cnt == 0) && !sl_wr;
  assign read_data_M       = read_data_valid_M ? sl_data : 32'hBAD0_BAD0;
  assign resp_M            = sl_resp;

  function automatic int predict_winner(input logic q0, input logic q1);
    if (q0 && q1) return FIXED ? 1 : (1 - model_last);
    return q1 ? 1 : 0;
  endfunction

  task automatic set_cmd(input int i, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req[i] = 1'b1; rw[i] = w; addr[i] = a; wdata[i] = d; wstrb[i] = s;
  endtask

  // drives nothing but the requester's req drop; captures what happened until `who` completes
  task automatic run_until_done(input int who, input int max_cyc, output bit seen,
                                output logic [31:0] rd, output logic [1:0] rs, output int n_acc,
                                output int gnt_who, output logic m_rw, output logic [31:0] m_a,
                                output logic [31:0] m_d, output logic [3:0] m_s, output bit quiet);
    seen = 0; n_acc = 0; gnt_who = -1; quiet = 1; rd = '0; rs = '0;
    m_rw = 1'b0; m_a = '0; m_d = '0; m_s = '0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge ACLK);
      if (M_access) begin
        n_acc++; m_rw = M_rd0_wr1; m_a = M_addr; m_d = M_write_data; m_s = M_write_strobe;
        gnt_who = gnt[1] ? 1 : (gnt[0] ? 0 : -1);
      end
      if (done[1-who] || rdata[1-who] != 0 || resp[1-who] != 0 || gnt[1-who]) quiet = 0;
      if (done[who]) begin
        seen = 1; rd = rdata[who]; rs = resp[who]; req[who] = 1'b0;
        $display("txn r%0d %s addr=%h rdata=%h resp=%0d", who, rw[who] ? "wr" : "rd", addr[who], rd, rs);
        break;
      end
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    @(negedge ACLK);
    n_checks++; if ({M_access, gnt[0], gnt[1], done[0], done[1], M_rd0_wr1} !== 6'b0) $display("FAIL reset_ctl: got %b want 000000", {M_access, gnt[0], gnt[1], done[0], done[1], M_rd0_wr1}); else n_pass++;
    n_checks++; if ({M_addr, M_write_data, M_write_strobe} !== 68'h0) $display("FAIL reset_cmd: got %h/%h/%h want 0", M_addr, M_write_data, M_write_strobe); else n_pass++;
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    n_checks++; if ({M_access, gnt[0], gnt[1]} !== 3'b0) $display("FAIL idle_after_reset: got %b want 000", {M_access, gnt[0], gnt[1]}); else n_pass++;
    model_last = 1;
  endtask

  task automatic test_single_read();
    bit seen, quiet; logic [31:0] rd, ma, md; logic [1:0] rs; int nacc, gw; logic mrw; logic [3:0] ms;
    cfg_lat = 2; cfg_data = 32'hDEAD_BEEF; cfg_resp = 2'b00;
    set_cmd(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
    run_until_done(0, 20, seen, rd, rs, nacc, gw, mrw, ma, md, ms, quiet);
    model_last = 0;
    n_checks++; if (!seen) $display("FAIL rd_done: got none want r0_done"); else n_pass++;
    n_checks++; if (rd !== 32'hDEAD_BEEF || rs !== 2'b00) $display("FAIL rd_data: got %h/%0d want deadbeef/0", rd, rs); else n_pass++;
    n_checks++; if (nacc != 1 || mrw !== 1'b0 || ma !== 32'h100 || gw != 0) $display("FAIL rd_access: got n=%0d rw=%b addr=%h gnt=%0d want 1/0/100/0", nacc, mrw, ma, gw); else n_pass++;
    n_checks++; if (!quiet) $display("FAIL rd_r1_quiet: got activity want none"); else n_pass++;
  endtask

  task automatic test_single_write();
    bit seen, quiet; logic [31:0] rd, ma, md; logic [1:0] rs; int nacc, gw; logic mrw; logic [3:0] ms;
    cfg_lat = 1; cfg_data = 32'h5555_AAAA; cfg_resp = 2'b00;
    set_cmd(1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF);
    run_until_done(1, 20, seen, rd, rs, nacc, gw, mrw, ma, md, ms, quiet);
    model_last = 1;
    n_checks++; if (!seen || rd !== 32'h0 || rs !== 2'b00) $display("FAIL wr_done: got seen=%0d rdata=%h resp=%0d want 1/0/0", seen, rd, rs); else n_pass++;
    n_checks++; if (md !== 32'h1234_5678 || ms !== 4'hF || mrw !== 1'b1 || ma !== 32'h200) $display("FAIL wr_cmd: got %h/%h/%b/%h want 12345678/f/1/200", md, ms, mrw, ma); else n_pass++;
    n_checks++; if (nacc != 1 || gw != 1 || !quiet) $display("FAIL wr_grant: got n=%0d gnt=%0d quiet=%0d want 1/1/1", nacc, gw, quiet); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int order[4]; int acc_c[4]; int done_c[4]; int na = 0, nd = 0; int w;
    cfg_lat = 1; cfg_resp = 2'b00; cfg_data = 32'h0BAD_CAFE;
    set_cmd(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 32'h0000_1004, 32'h0, 4'h0);
    for (int c = 0; c < 80 && nd < 4; c++) begin
      @(negedge ACLK);
      if (M_access && na < 4) begin order[na] = gnt[1] ? 1 : 0; acc_c[na] = c; na++; end
      if ((done[0] || done[1]) && nd < 4) begin
        done_c[nd] = c; nd++;
        $display("txn b2b r%0d rdata=%h", done[1] ? 1 : 0, done[1] ? rdata[1] : rdata[0]);
        if (nd == 4) begin req[0] = 1'b0; req[1] = 1'b0; end
      end
    end
    n_checks++; if (na != 4 || nd != 4) $display("FAIL b2b_count: got acc=%0d done=%0d want 4/4", na, nd); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      w = predict_winner(1'b1, 1'b1); model_last = w;
      n_checks++; if (k < na && order[k] != w) $display("FAIL b2b_order%0d: got r%0d want r%0d", k, order[k], w); else n_pass++;
      if (k > 0 && k < na) begin
        n_checks++; if (acc_c[k] - done_c[k-1] != 2) $display("FAIL b2b_bubble%0d: got gap %0d want 2", k, acc_c[k] - done_c[k-1]); else n_pass++;
      end
    end
  endtask

  task automatic test_wait_overlap();
    int done_c = -1, g1_c = -1; bit raised = 0; bit d1 = 0;
    cfg_lat = 3; cfg_data = 32'h0000_0300; cfg_resp = 2'b00;
    set_cmd(0, 1'b0, 32'h0000_0300, 32'h0, 4'h0);
    for (int c = 0; c < 40 && !d1; c++) begin
      @(negedge ACLK);
      if (M_access && gnt[1] && g1_c < 0) begin
        g1_c = c;
        n_checks++; if (M_addr !== 32'h400 || M_write_data !== 32'hA5A5_0001) $display("FAIL ovl_r1_cmd: got %h/%h want 400/a5a50001", M_addr, M_write_data); else n_pass++;
      end
      if (done[0]) begin
        done_c = c; req[0] = 1'b0;
        n_checks++; if (M_addr !== 32'h300 || gnt[1] !== 1'b0) $display("FAIL ovl_hold: got addr=%h g1=%b want 300/0", M_addr, gnt[1]); else n_pass++;
        $display("txn r0 rd addr=00000300 rdata=%h resp=%0d", rdata[0], resp[0]);
      end
      if (done[1]) begin d1 = 1; req[1] = 1'b0; $display("txn r1 wr addr=00000400 resp=%0d", resp[1]); end
      if (M_access && gnt[0] && !raised) begin raised = 1; set_cmd(1, 1'b1, 32'h0000_0400, 32'hA5A5_0001, 4'h3); end
    end
    model_last = 1;
    n_checks++; if (done_c < 0 || g1_c != done_c + 2) $display("FAIL ovl_grant: got r1 access at %0d want %0d", g1_c, done_c + 2); else n_pass++;
    n_checks++; if (!d1) $display("FAIL ovl_r1_done: got none want r1_done"); else n_pass++;
  endtask

  task automatic test_slverr();
    bit seen, quiet; logic [31:0] rd, ma, md; logic [1:0] rs; int nacc, gw; logic mrw; logic [3:0] ms;
    cfg_lat = 0; cfg_data = 32'hCAFE_F00D; cfg_resp = 2'b10;
    set_cmd(1, 1'b0, 32'h0000_0500, 32'h0, 4'h0);
    run_until_done(1, 20, seen, rd, rs, nacc, gw, mrw, ma, md, ms, quiet);
    model_last = 1;
    n_checks++; if (!seen || rs !== 2'b10 || rd !== 32'hCAFE_F00D) $display("FAIL slverr: got seen=%0d resp=%0d rdata=%h want 1/2/cafef00d", seen, rs, rd); else n_pass++;
    @(negedge ACLK);
    n_checks++; if ({gnt[0], gnt[1], M_access} !== 3'b0) $display("FAIL slverr_idle: got %b want 000", {gnt[0], gnt[1], M_access}); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    bit seen, quiet; logic [31:0] rd, ma, md; logic [1:0] rs; int nacc, gw; logic mrw; logic [3:0] ms;
    bit got_acc = 0; bit any_done = 0; int w;
    cfg_lat = 6; cfg_data = 32'h7777_7777; cfg_resp = 2'b00;
    set_cmd(0, 1'b0, 32'h0000_0600, 32'h0, 4'h0);
    for (int c = 0; c < 10 && !got_acc; c++) begin @(negedge ACLK); got_acc = M_access; end
    @(negedge ACLK);
    #2 ARESETn = 1'b0;
    #1;
    n_checks++; if ({gnt[0], gnt[1], M_access, done[0], done[1]} !== 5'b0 || M_addr !== 32'h0) $display("FAIL midrst_out: got %b addr=%h want 00000/0", {gnt[0], gnt[1], M_access, done[0], done[1]}, M_addr); else n_pass++;
    req[0] = 1'b0;
    for (int c = 0; c < 2; c++) begin @(negedge ACLK); if (done[0] || done[1]) any_done = 1; end
    ARESETn = 1'b1;
    model_last = 1;
    for (int c = 0; c < 3; c++) begin @(negedge ACLK); if (done[0] || done[1]) any_done = 1; end
    n_checks++; if (any_done) $display("FAIL midrst_nodone: got done pulse want none"); else n_pass++;
    cfg_lat = 1; cfg_data = 32'h1111_2222; cfg_resp = 2'b00;
    set_cmd(0, 1'b0, 32'h0000_0700, 32'h0, 4'h0);
    set_cmd(1, 1'b0, 32'h0000_0704, 32'h0, 4'h0);
    w = predict_winner(1'b1, 1'b1);
    run_until_done(w, 20, seen, rd, rs, nacc, gw, mrw, ma, md, ms, quiet);
    req[1-w] = 1'b0;
    model_last = w;
    n_checks++; if (!seen || gw != w || rd !== 32'h1111_2222 || rs !== 2'b00) $display("FAIL midrst_after: got seen=%0d gnt=%0d rdata=%h want 1/%0d/11112222", seen, gw, rd, w); else n_pass++;
    @(negedge ACLK);
  endtask

  task automatic test_random();
    int outstanding = -1; int last_done_c = -10; int wd = 0; int w; int ngr = 0; bit done_now[2];
    for (int c = 0; c < 600; c++) begin
      @(negedge ACLK);
      done_now[0] = done[0]; done_now[1] = done[1];
      if (M_access) begin
        w = predict_winner(req[0], req[1]);
        n_checks++;
        if (outstanding != -1 || !gnt[w] || gnt[1-w] || M_addr !== addr[w] || M_rd0_wr1 !== rw[w] || c - last_done_c < 2 ||
            (rw[w] && (M_write_data !== wdata[w] || M_write_strobe !== wstrb[w])))
          $display("FAIL rnd_grant: cyc %0d got g0=%b g1=%b addr=%h want r%0d addr=%h", c, gnt[0], gnt[1], M_addr, w, addr[w]);
        else n_pass++;
        model_last = w; outstanding = w; wd = 0; ngr++;
      end
      for (int i = 0; i < 2; i++) begin
        n_checks++; if (gnt[i] !== (outstanding == i)) $display("FAIL rnd_gnt%0d: cyc %0d got %b want %b", i, c, gnt[i], outstanding == i); else n_pass++;
        if (done[i]) begin
          n_checks++;
          if (outstanding != i || rdata[i] !== (rw[i] ? 32'h0 : sl_data) || resp[i] !== sl_resp || M_addr !== addr[i])
            $display("FAIL rnd_done%0d: cyc %0d got rdata=%h resp=%0d want %h/%0d", i, c, rdata[i], resp[i], rw[i] ? 32'h0 : sl_data, sl_resp);
          else n_pass++;
          $display("txn rnd r%0d %s addr=%h rdata=%h resp=%0d", i, rw[i] ? "wr" : "rd", addr[i], rdata[i], resp[i]);
          outstanding = -1; last_done_c = c; wd = 0;
        end else begin
          n_checks++; if (rdata[i] !== 32'h0 || resp[i] !== 2'b00) $display("FAIL rnd_quiet%0d: cyc %0d got %h/%0d want 0/0", i, c, rdata[i], resp[i]); else n_pass++;
        end
      end
      if (!M_access && !done[0] && !done[1] && (req[0] || req[1] || outstanding != -1)) wd++;
      if (wd > 20) begin
        n_checks++; $display("FAIL rnd_timeout: got no progress for %0d cycles want progress", wd);
        break;
      end
      for (int i = 0; i < 2; i++) begin
        if (done_now[i]) begin
          if ($urandom_range(0, 1) == 1) set_cmd(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)));
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          set_cmd(i, 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)));
        end
      end
      if (!M_access) begin
        cfg_lat = $urandom_range(0, 3); cfg_data = $urandom;
        case ($urandom_range(0, 3)) 2: cfg_resp = 2'b10; 3: cfg_resp = 2'b11; default: cfg_resp = 2'b00; endcase
      end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    n_checks++; if (ngr < 50) $display("FAIL rnd_activity: got %0d grants want >=50", ngr); else n_pass++;
    repeat (10) @(negedge ACLK);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin req[i] = 0; rw[i] = 0; addr[i] = 0; wdata[i] = 0; wstrb[i] = 0; end
    #1;
    test_reset();
    test_single_read();
    @(negedge ACLK);
    test_single_write();
    @(negedge ACLK);
    test_back_to_back();
    @(negedge ACLK);
    test_wait_overlap();
    @(negedge ACLK);
    test_slverr();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
